// File: rtl/imem_responder_if.sv
// Fetch-side handshake plus the external 16-bit SRAM read port of the instruction memory responder.
// Latency: wires only.
// Backpressure: busy is the freeze towards the fetch stage; the SRAM side has none.
interface imem_responder_if #(
    parameter int ADDR_W = 18
);
    logic              req;
    logic [31:0]       addr;
    logic              flush;
    logic              ack;
    logic [31:0]       instruction;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq;
    logic              sram_oe_n;

    // master = fetch stage together with the SRAM device; slave = the responder
    modport master (
        output req, addr, flush, sram_dq,
        input  ack, instruction, busy, err, sram_addr, sram_oe_n
    );

    modport slave (
        input  req, addr, flush, sram_dq,
        output ack, instruction, busy, err, sram_addr, sram_oe_n
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction fetch responder: assembles a 32-bit word from two 16-bit SRAM reads, one-entry word cache.
// Latency: miss 2*(WAIT_CYCLES+1)+1 cycles from the accepting edge to ack, hit 1 cycle.
// Backpressure: busy freezes the fetch stage while accepting or reading; flush aborts reads and gates ack.
module imem_responder #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    imem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int             WCW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES);

    state_t          state_q, state_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     low_q, low_d;
    logic [31:0]     instr_q, instr_d;
    logic            err_q, err_d;
    logic            cache_vld_q, cache_vld_d;
    logic [31:0]     cache_tag_q, cache_tag_d;
    logic [31:0]     cache_dat_q, cache_dat_d;

    logic            addr_legal;
    logic            accept;
    logic            hit;
    logic            phase_last;

    assign addr_legal = (bus.addr[1:0] == 2'b00) && (bus.addr[31:ADDR_W+1] == '0);
    assign accept     = (state_q == IDLE) && bus.req && !bus.flush;
    assign hit        = cache_vld_q && (cache_tag_q == bus.addr);
    assign phase_last = (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && addr_legal) begin
                    state_d = hit ? DONE : LOW;
                end
            end
            LOW: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (phase_last) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (phase_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.ack       = 1'b0;
        bus.busy      = 1'b0;
        bus.sram_oe_n = 1'b1;
        bus.sram_addr = '0;
        case (state_q)
            IDLE: begin
                bus.busy = bus.req && !bus.flush;
            end
            LOW: begin
                bus.busy      = 1'b1;
                bus.sram_oe_n = 1'b0;
                bus.sram_addr = addr_q[ADDR_W:1];
            end
            HIGH: begin
                bus.busy      = 1'b1;
                bus.sram_oe_n = 1'b0;
                bus.sram_addr = addr_q[ADDR_W:1] + ADDR_W'(1);
            end
            DONE: begin
                // busy stays low here so the fetch stage advances on the ack edge
                bus.ack = !bus.flush;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.err         = err_q;
    assign bus.instruction = instr_q;

    // Datapath: instruction and cache are loaded on the edge that enters DONE,
    // so a flush during DONE only gates ack and never the write.
    always_comb begin
        wait_d      = wait_q;
        addr_d      = addr_q;
        low_d       = low_q;
        instr_d     = instr_q;
        err_d       = 1'b0;
        cache_vld_d = cache_vld_q;
        cache_tag_d = cache_tag_q;
        cache_dat_d = cache_dat_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (accept) begin
                    if (addr_legal) begin
                        addr_d = bus.addr;
                        if (hit) begin
                            instr_d = cache_dat_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOW: begin
                if (bus.flush || phase_last) begin
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
                if (!bus.flush && phase_last) begin
                    low_d = bus.sram_dq;
                end
            end
            HIGH: begin
                if (bus.flush || phase_last) begin
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
                if (!bus.flush && phase_last) begin
                    instr_d     = {bus.sram_dq, low_q};
                    cache_vld_d = 1'b1;
                    cache_tag_d = addr_q;
                    cache_dat_d = {bus.sram_dq, low_q};
                end
            end
            DONE: begin
                wait_d = '0;
            end
            default: begin
                wait_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q      <= '0;
            addr_q      <= '0;
            low_q       <= '0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            cache_vld_q <= 1'b0;
            cache_tag_q <= '0;
            cache_dat_q <= '0;
        end else begin
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            low_q       <= low_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            cache_vld_q <= cache_vld_d;
            cache_tag_q <= cache_tag_d;
            cache_dat_q <= cache_dat_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: SRAM model plus a transaction-level cache/timing reference.
module tb_imem_responder;

    localparam int ADDR_W = 18;
    localparam int WAIT   = 1;
    localparam int MISS_CYC = 2 * (WAIT + 1) + 1;

    logic clk;
    logic rst;

    imem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    imem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:2047];
    assign bus.sram_dq = bus.sram_oe_n ? 16'h0000 : mem[bus.sram_addr[10:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // reference model state
    logic        m_vld;
    logic [31:0] m_tag;
    logic [31:0] m_dat;
    logic [31:0] m_instr;

    // {ack, busy, sram_oe_n, sram_addr, err}
    function automatic logic [21:0] pack_exp(input logic ack, input logic busy, input logic oe_n,
                                             input logic [ADDR_W-1:0] sa, input logic err);
        return {ack, busy, oe_n, sa, err};
    endfunction

    task automatic run_fetch(input logic [31:0] a, input int flush_at, input string tag);
        logic              legal;
        logic              hit;
        logic [ADDR_W-1:0] half;
        logic [10:0]       idx;
        logic [10:0]       idx1;
        logic [31:0]       exp_word;
        logic [21:0]       exp;
        logic [21:0]       obs;
        int                ncyc;
        legal    = (a[1:0] == 2'b00) && ((a >> (ADDR_W + 1)) == 0);
        hit      = legal && m_vld && (m_tag == a);
        half     = a[ADDR_W:1];
        idx      = half[10:0];
        idx1     = idx + 11'd1;
        exp_word = hit ? m_dat : {mem[idx1], mem[idx]};
        ncyc     = hit ? 1 : MISS_CYC;

        bus.req = 1'b1; bus.addr = a; bus.flush = 1'b0;
        #1;
        obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
        exp = pack_exp(1'b0, 1'b1, 1'b1, '0, 1'b0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s req-cycle got=%h want=%h", tag, obs, exp);
        end
        @(posedge clk); #1;
        bus.req = 1'b0;

        if (!legal) begin
            #1;
            obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
            exp = pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b1);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s err-pulse got=%h want=%h", tag, obs, exp);
            end
            @(posedge clk); #2;
            obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
            exp = pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s err-end got=%h want=%h", tag, obs, exp);
            end
            return;
        end

        for (int k = 1; k <= ncyc; k++) begin
            bus.flush = (k == flush_at);
            #1;
            obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
            if (k < ncyc) begin
                exp = pack_exp(1'b0, 1'b1, 1'b0, (k <= WAIT + 1) ? half : half + 1'b1, 1'b0);
            end else begin
                exp = pack_exp(k != flush_at, 1'b0, 1'b1, '0, 1'b0);
            end
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s cycle%0d got=%h want=%h", tag, k, obs, exp);
            end
            if (k == ncyc) begin
                vectors++;
                if (bus.instruction !== exp_word) begin
                    miscompares++;
                    $display("FAIL %s instruction got=%h want=%h", tag, bus.instruction, exp_word);
                end
            end
            if (k == flush_at && k < ncyc) begin
                @(posedge clk); #1;
                bus.flush = 1'b0;
                #1;
                obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
                exp = pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b0);
                vectors++;
                if (obs !== exp || bus.instruction !== m_instr) begin
                    miscompares++;
                    $display("FAIL %s abort got=%h/%h want=%h/%h", tag, obs, bus.instruction, exp, m_instr);
                end
                return;
            end
            @(posedge clk); #1;
        end
        bus.flush = 1'b0;
        if (!hit) begin
            m_vld = 1'b1;
            m_tag = a;
            m_dat = exp_word;
        end
        m_instr = exp_word;
        #1;
        obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
        exp = pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b0);
        vectors++;
        if (obs !== exp || bus.instruction !== m_instr) begin
            miscompares++;
            $display("FAIL %s hold got=%h/%h want=%h/%h", tag, obs, bus.instruction, exp, m_instr);
        end
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst = 1'b0; bus.req = 1'b0; bus.addr = '0; bus.flush = 1'b0;
        m_vld = 1'b0; m_tag = '0; m_dat = '0; m_instr = '0;
        #3;
        obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
        vectors++;
        if (obs !== pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b0) || bus.instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state got=%h/%h want=%h/0", obs, bus.instruction,
                     pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b0));
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_miss();
        run_fetch(32'h10, -1, "miss");
        vectors++;
        if (bus.instruction !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL miss_word got=%h want=deadbeef", bus.instruction);
        end
    endtask

    task automatic test_hit();
        run_fetch(32'h10, -1, "hit");
    endtask

    task automatic test_flush();
        run_fetch(32'h20, 3, "flush_high");
        run_fetch(32'h20, -1, "after_flush_miss");
        run_fetch(32'h30, 1, "flush_low");
    endtask

    task automatic test_bad_addr();
        run_fetch(32'h13, -1, "bad_align");
        run_fetch(32'h80000, -1, "bad_range");
    endtask

    task automatic test_flush_done();
        run_fetch(32'h40, MISS_CYC, "flush_done_miss");
        run_fetch(32'h40, 1, "flush_done_hit");
    endtask

    task automatic test_back_to_back();
        int          first;
        int          second;
        logic [31:0] w;
        w = {mem[11'h81], mem[11'h80]};
        first = -1; second = -1;
        bus.req = 1'b1; bus.addr = 32'h100; bus.flush = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #2;
            if (bus.ack === 1'b1) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (second >= 0) bus.req = 1'b0;
        end
        bus.req = 1'b0;
        vectors++;
        if (first != MISS_CYC || second != MISS_CYC + 2) begin
            miscompares++;
            $display("FAIL held_req ack cycles got=%0d,%0d want=%0d,%0d", first, second, MISS_CYC, MISS_CYC + 2);
        end
        vectors++;
        if (bus.instruction !== w) begin
            miscompares++;
            $display("FAIL held_req word got=%h want=%h", bus.instruction, w);
        end
        m_vld = 1'b1; m_tag = 32'h100; m_dat = w; m_instr = w;
    endtask

    task automatic test_reset_mid();
        logic [21:0] obs;
        bus.req = 1'b1; bus.addr = 32'h10; bus.flush = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        #1;
        vectors++;
        if (bus.sram_oe_n !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid pre oe_n got=%b want=0", bus.sram_oe_n);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        obs = {bus.ack, bus.busy, bus.sram_oe_n, bus.sram_addr, bus.err};
        vectors++;
        if (obs !== pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b0) || bus.instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid async got=%h/%h want=%h/0", obs, bus.instruction,
                     pack_exp(1'b0, 1'b0, 1'b1, '0, 1'b0));
        end
        m_vld = 1'b0; m_instr = '0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_fetch(32'h10, -1, "post_reset_miss");
    endtask

    task automatic test_random();
        logic [31:0] pool [0:5];
        logic [31:0] a;
        int          fa;
        pool[0] = 32'h10;  pool[1] = 32'h204; pool[2] = 32'h7F0;
        pool[3] = 32'hFF8; pool[4] = 32'h202; pool[5] = 32'h100000;
        for (int i = 0; i < 40; i++) begin
            a  = pool[$urandom_range(0, 5)];
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MISS_CYC)) : -1;
            run_fetch(a, fa, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        mem[8] = 16'hBEEF;
        mem[9] = 16'hDEAD;
        test_reset();
        test_miss();
        test_hit();
        test_flush();
        test_bad_addr();
        test_flush_done();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
